// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_pkg;

   // PC source select encoding
   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_JUMP   = 2'd1;
   localparam logic [1:0] PC_BRANCH = 2'd2;

   // Architectural zero register never creates a load-use dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Mul/div sequencing states
   typedef enum logic {
      StRun    = 1'b0,
      StMdWait = 1'b1
   } md_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // Count up on inc until the maximum value is reached
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken branch, multi-cycle mul/div and load-use hazards into stage controls.
module pipeline_stall_controller
   import pipeline_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             id_jump,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_bubble,
   output logic             mem_wb_en,
   output logic [1:0]       pc_sel,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned CTR_W = $clog2(MD_CYCLES);
   // The entry cycle in StRun already counts as one EX cycle of the operation
   localparam logic [CTR_W-1:0] MD_LOAD = CTR_W'(MD_CYCLES - 2);

   md_state_t        state_q, state_d;
   logic [CTR_W-1:0] md_ctr_q, md_ctr_d;

   logic mem_stall;
   logic md_busy;
   logic load_use;

   // Hazard detection
   always_comb begin
      mem_stall = mem_req & ~mem_ready;
      md_busy   = ((state_q == StRun) & ex_md_start) |
                  ((state_q == StMdWait) & (md_ctr_q != '0));
      load_use  = id_ex_mem_read & (id_ex_rt != REG_ZERO) &
                  ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
   end

   // Prioritised stage control decode; only the highest-priority hazard acts
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b1;
      ex_mem_bubble = 1'b0;
      mem_wb_en     = 1'b1;
      pc_sel        = PC_SEQ;
      // Result validity is independent of which hazard wins
      md_done       = (state_q == StMdWait) & (md_ctr_q == '0);

      if (mem_stall) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         pc_sel      = PC_BRANCH;
      end else if (md_busy) begin
         // ID/EX holds because its enable is pc_en
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         ex_mem_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_jump) begin
         if_id_flush = 1'b1;
         pc_sel      = PC_JUMP;
      end
   end

   // Mul/div occupancy sequencing; the unit keeps counting through memory stalls
   always_comb begin
      state_d  = state_q;
      md_ctr_d = md_ctr_q;
      case (state_q)
         StRun: begin
            if (ex_md_start && !mem_stall && !ex_branch_taken) begin
               state_d  = StMdWait;
               md_ctr_d = MD_LOAD;
            end
         end
         StMdWait: begin
            if (md_ctr_q != '0) begin
               md_ctr_d = md_ctr_q - CTR_W'(1);
            end else if (!mem_stall) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d  = StRun;
            md_ctr_d = '0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StRun;
         md_ctr_q <= '0;
      end else begin
         state_q  <= state_d;
         md_ctr_q <= md_ctr_d;
      end
   end

   logic stall_inc;
   logic flush_inc;

   // Performance counter increment conditions
   always_comb begin
      stall_inc = ~pc_en;
      flush_inc = if_id_flush;
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Arbitrates four hazard sources into one set of per-stage enables, flushes and the PC-select: memory wait, taken branch in EX, multi-cycle mul/div in EX, and load-use between ID/EX and IF/ID.
- Sequences the multi-cycle mul/div occupancy with a cycle counter.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MD_CYCLES, 8: total EX-stage cycles a mul/div occupies (≥2).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_ex_mem_read  in  1  instruction in ID/EX is a load.
- id_ex_rt  in  5  load destination register.
- if_id_rs  in  5  rs field of the instruction in IF/ID.
- if_id_rt  in  5  rt field of the instruction in IF/ID.
- id_jump  in  1  instruction in ID is j/jal.
- ex_branch_taken  in  1  beq/bne in EX resolved taken.
- ex_md_start  in  1  instruction in EX is mul/div.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory has completed the access.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID cleared to NOP on this edge.
- id_ex_flush  out  1  ID/EX cleared to bubble on this edge.
- ex_mem_en  out  1  EX/MEM write enable.
- ex_mem_bubble  out  1  EX/MEM loaded with a bubble.
- mem_wb_en  out  1  MEM/WB write enable.
- pc_sel  out  2  PC source: 0 = PC+4, 1 = jump, 2 = branch.
- md_done  out  1  mul/div result valid this cycle.
- stall_cnt  out  CNT_W  cycles with pc_en = 0.
- flush_cnt  out  CNT_W  cycles with if_id_flush = 1.

Behaviour:
- State FSM: RUN, MD_WAIT. md_ctr width is clog2(MD_CYCLES).
- All outputs except the counters are combinational from state, md_ctr and the current inputs. The state, md_ctr and counters are registered.
- Reset (rst = 0, async): state = RUN, md_ctr = 0, stall_cnt = 0, flush_cnt = 0.
- Reset-time outputs follow from the decode with inputs low: pc_en = if_id_en = ex_mem_en = mem_wb_en = 1, other outputs 0.
- Defaults: all enables 1, flushes and bubbles 0, pc_sel = 0, md_done = 0.
- Priority, highest first; only the first matching rule applies:
  1. mem_stall = mem_req & ~mem_ready. All enables 0, no flushes, pc_sel = 0. Full freeze.
  2. ex_branch_taken. if_id_flush = 1, id_ex_flush = 1, pc_sel = 2. Younger hazards are discarded.
  3. md_busy, defined as (state == RUN & ex_md_start) | (state == MD_WAIT & md_ctr != 0). pc_en = 0, if_id_en = 0, ex_mem_bubble = 1. ID/EX holds because its enable is pc_en.
  4. load_use, defined as id_ex_mem_read & id_ex_rt != 0 & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt). pc_en = 0, if_id_en = 0, id_ex_flush = 1. This is a 1-cycle bubble.
  5. id_jump. if_id_flush = 1, pc_sel = 1.
- FSM transitions:
  - RUN → MD_WAIT when ex_md_start & ~mem_stall & ~ex_branch_taken. Load md_ctr = MD_CYCLES-2.
  - In MD_WAIT, md_ctr decrements every cycle, including during mem_stall, because the unit runs independently.
  - MD_WAIT with md_ctr == 0: md_done = 1, the stall is released and the instruction advances. Go to RUN unless mem_stall, in which case stay until ~mem_stall; md_done stays 1.
  - Net result: a mul/div with no mem stalls holds EX for exactly MD_CYCLES cycles.
- ex_md_start held high in MD_WAIT does not restart the counter.
- Performance counters:
  - stall_cnt increments on each cycle with pc_en = 0.
  - flush_cnt increments on each cycle with if_id_flush = 1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- A reset asserted mid-MD_WAIT aborts the sequence immediately. The next cycle is RUN with no stall.

Decomposition:
- Shared package pipeline_pkg holds:
  - the pc_sel encoding constants PC_SEQ = 0, PC_JUMP = 1, PC_BRANCH = 2;
  - the FSM state enum;
  - REG_ZERO = 5'd0.
- One natural sub-module: sat_counter (parameter W, inputs inc and rst), instantiated twice for the performance counters.

Test Plan:
- Load-use: id_ex_mem_read = 1, id_ex_rt = 8, if_id_rs = 8 for one cycle → pc_en = 0, if_id_en = 0, id_ex_flush = 1 for 1 cycle; stall_cnt = 1. Same stimulus with id_ex_rt = 0 → no stall.
- Branch beats load-use and jump: ex_branch_taken = 1 together with a load_use match and id_jump = 1 → pc_sel = 2, if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt + 1.
- Mul/div, MD_CYCLES = 8: ex_md_start held high → pc_en = 0 for 7 cycles, then md_done = 1 and pc_en = 1 on the 8th; state returns to RUN; stall_cnt = 7.
- Mem stall inside mul/div: mem_req = 1, mem_ready = 0 for 10 cycles starting at MD_WAIT cycle 3 → all enables 0 throughout; md_done = 1 while frozen; RUN entered on the cycle after mem_ready = 1.
- Async reset mid-MD_WAIT: rst = 0 between clock edges → outputs return to their reset values immediately; counters = 0.
- Saturation, CNT_W = 4: 20 consecutive load-use stalls → stall_cnt = 15 and holds at 15.
